// File: rtl/bin_to_dec_emitter.sv
// Sequential double-dabble converter that streams an 8-bit value as one-hot
// decimal digits, most significant first, over a valid/ready handshake.
module bin_to_dec_emitter #(
    parameter bit SUPPRESS_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] value,
    input  logic       ready,
    output logic       busy,
    output logic       digit_valid,
    output logic       zero,
    output logic       one,
    output logic       two,
    output logic       three,
    output logic       four,
    output logic       five,
    output logic       six,
    output logic       seven,
    output logic       eight,
    output logic       nine,
    output logic [3:0] digit_bin,
    output logic [1:0] digit_pos,
    output logic       last,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        EMIT,
        DONE
    } state_t;

    state_t      state_q;
    logic [19:0] sr_q;
    logic [19:0] adj_d;
    logic [19:0] sr_d;
    logic [3:0]  cnt_q;
    logic [1:0]  pos_q;
    logic [1:0]  first_d;
    logic [3:0]  dig_q;
    logic        valid_q;
    logic        last_q;
    logic        busy_q;
    logic        done_q;
    logic [9:0]  onehot;

    function automatic logic [3:0] nib(input logic [11:0] b, input logic [1:0] p);
        logic [3:0] r;
        unique case (p)
            2'd2:    r = b[11:8];
            2'd1:    r = b[7:4];
            default: r = b[3:0];
        endcase
        return r;
    endfunction

    // Add-3 correction on every BCD nibble precedes the shift.
    always_comb begin
        adj_d = sr_q;
        for (int i = 0; i < 3; i++) begin
            if (sr_q[8+4*i +: 4] >= 4'd5)
                adj_d[8+4*i +: 4] = sr_q[8+4*i +: 4] + 4'd3;
        end
        sr_d = adj_d << 1;
    end

    always_comb begin
        first_d = 2'd2;
        if (SUPPRESS_LZ) begin
            if (sr_q[19:16] != 4'd0)      first_d = 2'd2;
            else if (sr_q[15:12] != 4'd0) first_d = 2'd1;
            else                          first_d = 2'd0;
        end
    end

    // The extra CONVERT cycle at cnt_q == 8 selects the first digit position.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            dig_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sr_q    <= {12'd0, value};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (cnt_q == 4'd8) begin
                        state_q <= EMIT;
                        pos_q   <= first_d;
                        dig_q   <= nib(sr_q[19:8], first_d);
                        valid_q <= 1'b1;
                        last_q  <= (first_d == 2'd0);
                    end else begin
                        sr_q  <= sr_d;
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                EMIT: begin
                    if (ready) begin
                        if (pos_q == 2'd0) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            dig_q   <= '0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            pos_q  <= pos_q - 2'd1;
                            dig_q  <= nib(sr_q[19:8], pos_q - 2'd1);
                            last_q <= (pos_q == 2'd1);
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign onehot = valid_q ? (10'd1 << dig_q) : 10'd0;
    assign {nine, eight, seven, six, five, four, three, two, one, zero} = onehot;

    assign busy        = busy_q;
    assign digit_valid = valid_q;
    assign digit_bin   = valid_q ? dig_q : 4'd0;
    assign digit_pos   = valid_q ? pos_q : 2'd0;
    assign last        = valid_q & last_q;
    assign done        = done_q;

endmodule

// File: tb/tb_bin_to_dec_emitter.sv
// Scoreboard bench: two emitters (leading-zero suppression on and off) share
// stimulus; a negedge monitor pops expected digits on every handshake.
module tb_bin_to_dec_emitter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] value;
    wire        ready;
    logic       rdy_rand;
    logic       rdy_force;
    logic       rnd_bit;

    wire        busy_a, dv_a, last_a, done_a;
    wire [9:0]  oh_a;
    wire [3:0]  bin_a;
    wire [1:0]  pos_a;
    wire        busy_b, dv_b, last_b, done_b;
    wire [9:0]  oh_b;
    wire [3:0]  bin_b;
    wire [1:0]  pos_b;

    int checks = 0;
    int errors = 0;

    logic [6:0] qa[$];
    logic [6:0] qb[$];
    logic [1:0] exp_done;
    logic [1:0] stalled;
    logic [6:0] held [2];

    logic       m_v, m_last, m_done;
    logic [9:0] m_oh;
    logic [3:0] m_bin;
    logic [1:0] m_pos;
    logic [6:0] m_e;

    always #5 clk = ~clk;

    assign ready = rdy_rand ? rnd_bit : rdy_force;

    always @(posedge clk) begin
        #1 rnd_bit = ($urandom % 4) != 0;
    end

    bin_to_dec_emitter #(.SUPPRESS_LZ(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .value(value), .ready(ready),
        .busy(busy_a), .digit_valid(dv_a),
        .zero(oh_a[0]), .one(oh_a[1]), .two(oh_a[2]), .three(oh_a[3]),
        .four(oh_a[4]), .five(oh_a[5]), .six(oh_a[6]), .seven(oh_a[7]),
        .eight(oh_a[8]), .nine(oh_a[9]),
        .digit_bin(bin_a), .digit_pos(pos_a), .last(last_a), .done(done_a)
    );

    bin_to_dec_emitter #(.SUPPRESS_LZ(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .value(value), .ready(ready),
        .busy(busy_b), .digit_valid(dv_b),
        .zero(oh_b[0]), .one(oh_b[1]), .two(oh_b[2]), .three(oh_b[3]),
        .four(oh_b[4]), .five(oh_b[5]), .six(oh_b[6]), .seven(oh_b[7]),
        .eight(oh_b[8]), .nine(oh_b[9]),
        .digit_bin(bin_b), .digit_pos(pos_b), .last(last_b), .done(done_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: decimal digits by division; suppression starts at the
    // highest nonzero digit, otherwise always at hundreds.
    function automatic void push_exp(input int d, input int v);
        int dig [3];
        int p;
        logic [6:0] e;
        dig[2] = v / 100;
        dig[1] = (v / 10) % 10;
        dig[0] = v % 10;
        if (d == 0) p = (v >= 100) ? 2 : ((v >= 10) ? 1 : 0);
        else        p = 2;
        for (int i = p; i >= 0; i--) begin
            e = {4'(dig[i]), 2'(i), (i == 0)};
            if (d == 0) qa.push_back(e);
            else        qb.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                m_v    = (d == 0) ? dv_a   : dv_b;
                m_oh   = (d == 0) ? oh_a   : oh_b;
                m_bin  = (d == 0) ? bin_a  : bin_b;
                m_pos  = (d == 0) ? pos_a  : pos_b;
                m_last = (d == 0) ? last_a : last_b;
                m_done = (d == 0) ? done_a : done_b;
                chk($sformatf("done_%0d", d), m_done, exp_done[d]);
                exp_done[d] = 1'b0;
                if (m_v) begin
                    chk($sformatf("onehot_%0d", d), m_oh, 10'd1 << m_bin);
                    if (stalled[d])
                        chk($sformatf("hold_%0d", d), {m_bin, m_pos, m_last}, held[d]);
                    if (ready) begin
                        stalled[d] = 1'b0;
                        if ((d == 0 ? qa.size() : qb.size()) == 0) begin
                            chk($sformatf("extra_digit_%0d", d), m_bin, 99);
                        end else begin
                            m_e = (d == 0) ? qa.pop_front() : qb.pop_front();
                            chk($sformatf("digit_%0d", d), m_bin, m_e[6:3]);
                            chk($sformatf("pos_%0d", d), m_pos, m_e[2:1]);
                            chk($sformatf("last_%0d", d), m_last, m_e[0]);
                            if (m_e[0]) exp_done[d] = 1'b1;
                        end
                    end else begin
                        stalled[d] = 1'b1;
                        held[d] = {m_bin, m_pos, m_last};
                    end
                end else begin
                    chk($sformatf("idle_lines_%0d", d), {m_oh, m_bin, m_last}, 0);
                    if (stalled[d]) begin
                        chk($sformatf("dropped_%0d", d), 0, 1);
                        stalled[d] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy_a || busy_b) begin
            @(negedge clk);
            n++;
            if (n > 400) begin
                chk("idle_timeout", 1, 0);
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_dv();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dv_a && n < 60);
        if (!dv_a) chk("valid_timeout", 0, 1);
    endtask

    task automatic issue(input logic [7:0] v, input bit meas,
                         input int exp_lat, input int exp_busy);
        int lat;
        int bcnt;
        wait_idle();
        @(posedge clk);
        #1;
        start = 1'b1;
        value = v;
        push_exp(0, v);
        push_exp(1, v);
        @(posedge clk);
        #1;
        start = 1'b0;
        value = 8'($urandom);
        if (meas) begin
            lat  = -1;
            bcnt = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (busy_a) bcnt++;
                if (dv_a && lat < 0) lat = i;
                if (!busy_a) break;
            end
            chk("latency", lat, exp_lat);
            chk("busy_len", bcnt, exp_busy);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_a", {busy_a, dv_a, oh_a, bin_a, pos_a, last_a, done_a}, 0);
        chk("rst_b", {busy_b, dv_b, oh_b, bin_b, pos_b, last_b, done_b}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        value     = 8'd0;
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        exp_done  = '0;
        stalled   = '0;
        held[0]   = '0;
        held[1]   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs();

        issue(8'd0, 1'b1, 9, 11);
        issue(8'd255, 1'b1, 9, 13);
        issue(8'd7, 1'b0, 0, 0);

        issue(8'd105, 1'b0, 0, 0);
        rdy_force = 1'b0;
        wait_dv();
        repeat (4) @(posedge clk);
        #1 rdy_force = 1'b1;

        issue(8'd199, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        value = 8'd42;
        @(posedge clk);
        #1 start = 1'b0;

        issue(8'd250, 1'b0, 0, 0);
        wait_dv();
        @(posedge clk);
        #1;
        rdy_force = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        qa.delete();
        qb.delete();
        stalled  = '0;
        exp_done = '0;
        rdy_force = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        issue(8'd3, 1'b0, 0, 0);

        rdy_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            issue(8'($urandom), 1'b0, 0, 0);
            if ($urandom % 2 == 1) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
                start = 1'b1;
                value = 8'($urandom);
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
